// File: rtl/accumulator_execute_pkg.sv
// Shared types and constants for the PUC CPU execute stage.
package puc_pkg;

    localparam int OPCODE_WIDTH = 4;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ADDI = 4'h2,
        OP_SUBI = 4'h3,
        OP_ANDI = 4'h4,
        OP_ORI  = 4'h5,
        OP_XORI = 4'h6,
        OP_SHLI = 4'h7,
        OP_MULI = 4'h8,
        OP_JMP  = 4'h9,
        OP_JZ   = 4'hA,
        OP_HALT = 4'hB
    } opcode_t;

    typedef enum logic [1:0] {
        EXEC,
        MUL,
        HALTED
    } state_t;

    localparam state_t RST_STATE       = EXEC;
    localparam logic   RST_ZERO_FLAG   = 1'b1;
    localparam logic   RST_CARRY_FLAG  = 1'b0;
    localparam logic   RST_JUMP_VALID  = 1'b0;
    localparam logic   RST_ILLEGAL     = 1'b0;

    // Immediate field is whatever remains of the word below the opcode.
    function automatic int imm_width(input int word_width);
        return word_width - OPCODE_WIDTH;
    endfunction

endpackage

// File: rtl/accumulator_execute_shift_add_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per clock.
// done is high during the final iteration; product is valid in that cycle.
module shift_add_multiplier #(
    parameter int ACC_WIDTH = 8,
    parameter int IMM_WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ACC_WIDTH-1:0] multiplicand,
    input  logic [IMM_WIDTH-1:0] multiplier,
    output logic [ACC_WIDTH-1:0] product,
    output logic                 done
);

    localparam int CW = $clog2(IMM_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(IMM_WIDTH - 1);

    logic                 active;
    logic [CW-1:0]        count;
    logic [ACC_WIDTH-1:0] mcand;
    logic [IMM_WIDTH-1:0] mplier;
    logic [ACC_WIDTH-1:0] partial;
    logic [ACC_WIDTH-1:0] partial_next;

    // Add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        partial_next = partial + (mplier[0] ? mcand : '0);
    end

    assign product = partial_next;
    assign done    = active && (count == LAST);

    // Load operands on start, then shift and accumulate for IMM_WIDTH cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active  <= 1'b0;
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            partial <= '0;
        end else if (start) begin
            active  <= 1'b1;
            count   <= '0;
            mcand   <= multiplicand;
            mplier  <= multiplier;
            partial <= '0;
        end else if (active) begin
            partial <= partial_next;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            if (count == LAST) begin
                active <= 1'b0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/accumulator_execute.sv
// Execute stage of the PUC CPU: accumulator ALU, flags, jumps, multiply, halt.
module accumulator_execute
    import puc_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int COUNTER_WIDTH = 4,
    parameter int ACC_WIDTH     = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         instruction,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    output logic [ACC_WIDTH-1:0]     acc,
    output logic                     zero_flag,
    output logic                     carry_flag,
    output logic                     jump_valid,
    output logic [COUNTER_WIDTH-1:0] jump_target,
    output logic                     busy,
    output logic                     halted,
    output logic                     illegal
);

    localparam int IMM_WIDTH = imm_width(WIDTH);

    state_t state, state_next;

    logic [OPCODE_WIDTH-1:0]  opcode;
    logic [IMM_WIDTH-1:0]     imm;
    logic [ACC_WIDTH-1:0]     imm_ext;
    logic [ACC_WIDTH:0]       sum_ext;
    logic [ACC_WIDTH:0]       diff_ext;
    logic                     accept;

    logic [ACC_WIDTH-1:0]     acc_next;
    logic                     acc_we;
    logic                     carry_next;
    logic                     jump_valid_next;
    logic [COUNTER_WIDTH-1:0] jump_target_next;
    logic                     illegal_next;

    logic                     mul_start;
    logic [ACC_WIDTH-1:0]     mul_product;
    logic                     mul_done;

    assign opcode   = instruction[WIDTH-1 -: OPCODE_WIDTH];
    assign imm      = instruction[IMM_WIDTH-1:0];
    assign imm_ext  = ACC_WIDTH'(imm);
    assign sum_ext  = {1'b0, acc} + {1'b0, imm_ext};
    assign diff_ext = {1'b0, acc} - {1'b0, imm_ext};

    assign instr_ready = (state == EXEC);
    assign busy        = (state == MUL);
    assign halted      = (state == HALTED);
    assign accept      = instr_valid && instr_ready;
    assign mul_start   = accept && (opcode == OP_MULI);

    shift_add_multiplier #(
        .ACC_WIDTH (ACC_WIDTH),
        .IMM_WIDTH (IMM_WIDTH)
    ) u_mul (
        .clock        (clock),
        .reset        (reset),
        .start        (mul_start),
        .multiplicand (acc),
        .multiplier   (imm),
        .product      (mul_product),
        .done         (mul_done)
    );

    // Decode the accepted instruction and compute next state, acc and flags.
    always_comb begin
        state_next       = state;
        acc_next         = acc;
        acc_we           = 1'b0;
        carry_next       = carry_flag;
        jump_valid_next  = 1'b0;
        jump_target_next = jump_target;
        illegal_next     = 1'b0;

        case (state)
            EXEC: begin
                if (accept) begin
                    case (opcode)
                        OP_NOP:  ;
                        OP_LDI:  begin acc_next = imm_ext;       acc_we = 1'b1; end
                        OP_ADDI: begin
                            acc_next   = sum_ext[ACC_WIDTH-1:0];
                            carry_next = sum_ext[ACC_WIDTH];
                            acc_we     = 1'b1;
                        end
                        OP_SUBI: begin
                            acc_next   = diff_ext[ACC_WIDTH-1:0];
                            carry_next = diff_ext[ACC_WIDTH];
                            acc_we     = 1'b1;
                        end
                        OP_ANDI: begin acc_next = acc & imm_ext; acc_we = 1'b1; end
                        OP_ORI:  begin acc_next = acc | imm_ext; acc_we = 1'b1; end
                        OP_XORI: begin acc_next = acc ^ imm_ext; acc_we = 1'b1; end
                        OP_SHLI: begin acc_next = acc << imm_ext[2:0]; acc_we = 1'b1; end
                        OP_MULI: state_next = MUL;
                        OP_JMP: begin
                            jump_valid_next  = 1'b1;
                            jump_target_next = COUNTER_WIDTH'(imm);
                        end
                        OP_JZ: begin
                            if (zero_flag) begin
                                jump_valid_next  = 1'b1;
                                jump_target_next = COUNTER_WIDTH'(imm);
                            end
                        end
                        OP_HALT: state_next = HALTED;
                        default: illegal_next = 1'b1;
                    endcase
                end
            end
            MUL: begin
                if (mul_done) begin
                    acc_next   = mul_product;
                    acc_we     = 1'b1;
                    state_next = EXEC;
                end
            end
            HALTED: ;
            default: state_next = RST_STATE;
        endcase
    end

    // Architectural registers; reset aborts everything including a multiply.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RST_STATE;
            acc         <= '0;
            zero_flag   <= RST_ZERO_FLAG;
            carry_flag  <= RST_CARRY_FLAG;
            jump_valid  <= RST_JUMP_VALID;
            jump_target <= '0;
            illegal     <= RST_ILLEGAL;
        end else begin
            state       <= state_next;
            acc         <= acc_next;
            if (acc_we) begin
                zero_flag <= (acc_next == '0);
            end
            carry_flag  <= carry_next;
            jump_valid  <= jump_valid_next;
            jump_target <= jump_target_next;
            illegal     <= illegal_next;
        end
    end

endmodule

// File: tb/tb_accumulator_execute.sv
// Self-checking bench for accumulator_execute against a behavioural model.
module tb_accumulator_execute;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] instruction;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] acc;
    logic       zero_flag;
    logic       carry_flag;
    logic       jump_valid;
    logic [3:0] jump_target;
    logic       busy;
    logic       halted;
    logic       illegal;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    int m_acc;
    bit m_zero, m_carry, m_jv, m_ill, m_halt;
    int m_jt;

    accumulator_execute #(
        .WIDTH         (8),
        .COUNTER_WIDTH (4),
        .ACC_WIDTH     (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .acc         (acc),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal)
    );

    always #5 clock = ~clock;

    function automatic void model_reset();
        m_acc = 0; m_zero = 1; m_carry = 0; m_jv = 0; m_ill = 0; m_halt = 0; m_jt = 0;
    endfunction

    // Architectural effect of one accepted instruction, from the opcode table.
    function automatic void model_step(input logic [7:0] ins);
        int op, imm;
        bit wr;
        op = int'(ins[7:4]);
        imm = int'(ins[3:0]);
        wr = 0;
        m_jv = 0;
        m_ill = 0;
        if (m_halt) return;
        case (op)
            1: begin m_acc = imm; wr = 1; end
            2: begin m_acc = m_acc + imm; m_carry = (m_acc > 255); m_acc = m_acc % 256; wr = 1; end
            3: begin m_carry = (m_acc < imm); m_acc = (m_acc - imm + 256) % 256; wr = 1; end
            4: begin m_acc = m_acc & imm; wr = 1; end
            5: begin m_acc = m_acc | imm; wr = 1; end
            6: begin m_acc = m_acc ^ imm; wr = 1; end
            7: begin m_acc = (m_acc << (imm % 8)) % 256; wr = 1; end
            8: begin m_acc = (m_acc * imm) % 256; wr = 1; end
            9: begin m_jv = 1; m_jt = imm % 16; end
            10: if (m_zero) begin m_jv = 1; m_jt = imm % 16; end
            11: m_halt = 1;
            12, 13, 14, 15: m_ill = 1;
            default: ;
        endcase
        if (wr) m_zero = (m_acc == 0);
    endfunction

    function automatic logic [18:0] exp_vec();
        logic [7:0] a;
        logic [3:0] t;
        a = m_acc[7:0];
        t = m_jt[3:0];
        return {a, m_zero, m_carry, m_jv, t, m_ill, m_halt, !m_halt, 1'b0};
    endfunction

    function automatic logic [18:0] obs_vec();
        return {acc, zero_flag, carry_flag, jump_valid, jump_target, illegal, halted, instr_ready, busy};
    endfunction

    // Present one instruction for one edge; for MULI wait (bounded) for ready.
    task automatic issue(input logic [7:0] ins, output int waited);
        instruction = ins;
        instr_valid = 1'b1;
        @(posedge clock); #1;
        instr_valid = 1'b0;
        model_step(ins);
        waited = 0;
        if (ins[7:4] == 4'h8) begin
            while (!instr_ready && waited < 16) begin
                @(posedge clock); #1;
                waited++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            m_jv = 0;
            m_ill = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", obs_vec(), exp_vec());
        end
        @(posedge clock); #1;
    endtask

    task automatic test_ldi();
        int w;
        issue(8'h15, w);
        n_cmp++;
        if ({acc, zero_flag, instr_ready} !== {8'd5, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL ldi5: got acc=%0d z=%b rdy=%b expected acc=5 z=0 rdy=1", acc, zero_flag, instr_ready);
        end
    endtask

    task automatic test_muli();
        int w;
        issue(8'h1F, w);
        instruction = 8'h8F;
        instr_valid = 1'b1;
        @(posedge clock); #1;
        model_step(8'h8F);
        // hold an LDI 9 on the bus through the whole busy window
        instruction = 8'h19;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({busy, instr_ready} !== 2'b10) begin
                n_fail++;
                $display("FAIL muli_busy_cycle%0d: got busy=%b rdy=%b expected busy=1 rdy=0", k, busy, instr_ready);
            end
            @(posedge clock); #1;
        end
        n_cmp++;
        if (obs_vec() !== exp_vec() || acc !== 8'hE1) begin
            n_fail++;
            $display("FAIL muli_result: got %h expected %h (acc E1)", obs_vec(), exp_vec());
        end
        @(posedge clock); #1;
        instr_valid = 1'b0;
        model_step(8'h19);
        n_cmp++;
        if (acc !== 8'd9) begin
            n_fail++;
            $display("FAIL held_ldi_after_mul: got acc=%0d expected 9", acc);
        end
        // MULI with imm=0 still spends the full iteration count
        issue(8'h80, w);
        n_cmp++;
        if (w !== 4 || obs_vec() !== exp_vec() || acc !== 8'd0) begin
            n_fail++;
            $display("FAIL muli_zero: got wait=%0d vec=%h expected wait=4 vec=%h", w, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_add_sub();
        int w;
        issue(8'h1F, w);
        issue(8'h8F, w);
        issue(8'h2F, w);
        n_cmp++;
        if ({acc, carry_flag} !== {8'd240, 1'b0}) begin
            n_fail++;
            $display("FAIL addi_240: got acc=%0d c=%b expected 240 c=0", acc, carry_flag);
        end
        issue(8'h2F, w);
        n_cmp++;
        if ({acc, carry_flag} !== {8'd255, 1'b0}) begin
            n_fail++;
            $display("FAIL addi_255: got acc=%0d c=%b expected 255 c=0", acc, carry_flag);
        end
        issue(8'h21, w);
        n_cmp++;
        if ({acc, carry_flag, zero_flag} !== {8'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL addi_wrap: got acc=%0d c=%b z=%b expected 0 c=1 z=1", acc, carry_flag, zero_flag);
        end
        issue(8'h31, w);
        n_cmp++;
        if ({acc, carry_flag, zero_flag} !== {8'd255, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL subi_borrow: got acc=%0d c=%b z=%b expected 255 c=1 z=0", acc, carry_flag, zero_flag);
        end
    endtask

    task automatic test_jumps();
        int w;
        issue(8'h10, w);
        issue(8'hA7, w);
        n_cmp++;
        if ({jump_valid, jump_target} !== {1'b1, 4'd7}) begin
            n_fail++;
            $display("FAIL jz_taken: got jv=%b jt=%0d expected jv=1 jt=7", jump_valid, jump_target);
        end
        idle(1);
        n_cmp++;
        if ({jump_valid, jump_target} !== {1'b0, 4'd7}) begin
            n_fail++;
            $display("FAIL jz_one_cycle: got jv=%b jt=%0d expected jv=0 jt=7", jump_valid, jump_target);
        end
        issue(8'h11, w);
        issue(8'hA7, w);
        n_cmp++;
        if ({jump_valid, jump_target} !== {1'b0, 4'd7}) begin
            n_fail++;
            $display("FAIL jz_not_taken: got jv=%b jt=%0d expected jv=0 jt=7", jump_valid, jump_target);
        end
        issue(8'h93, w);
        n_cmp++;
        if ({jump_valid, jump_target} !== {1'b1, 4'd3}) begin
            n_fail++;
            $display("FAIL jmp: got jv=%b jt=%0d expected jv=1 jt=3", jump_valid, jump_target);
        end
        // JZ right after an LDI 0 sees the zero flag that LDI just wrote
        issue(8'h10, w);
        issue(8'hA5, w);
        n_cmp++;
        if (obs_vec() !== exp_vec() || jump_target !== 4'd5) begin
            n_fail++;
            $display("FAIL jz_after_ldi0: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_illegal();
        int w;
        issue(8'h1C, w);
        issue(8'hE0, w);
        n_cmp++;
        if (obs_vec() !== exp_vec() || illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_pulse: got %h expected %h", obs_vec(), exp_vec());
        end
        idle(1);
        n_cmp++;
        if (obs_vec() !== exp_vec() || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_clear: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int w;
        logic [7:0] ins;
        for (int i = 0; i < 200; i++) begin
            ins = 8'($urandom);
            if (ins[7:4] == 4'hB) ins[7:4] = 4'h0;
            issue(ins, w);
            n_cmp++;
            if (obs_vec() !== exp_vec() || (ins[7:4] == 4'h8 && w !== 4)) begin
                n_fail++;
                $display("FAIL random_%0d ins=%h: got %h wait=%0d expected %h", i, ins, obs_vec(), w, exp_vec());
            end
            if ($urandom_range(0, 3) == 0) idle(1);
        end
    endtask

    task automatic test_halt();
        int w;
        issue(8'h16, w);
        issue(8'hB0, w);
        n_cmp++;
        if ({halted, instr_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL halt_enter: got halted=%b rdy=%b expected 1 0", halted, instr_ready);
        end
        instruction = 8'h19;
        instr_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        instr_valid = 1'b0;
        n_cmp++;
        if (obs_vec() !== exp_vec() || acc !== 8'd6) begin
            n_fail++;
            $display("FAIL halt_ignores: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_async_reset();
        int w;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        @(posedge clock); #1;
        issue(8'h1F, w);
        instruction = 8'h8F;
        instr_valid = 1'b1;
        @(posedge clock); #1;
        instr_valid = 1'b0;
        @(posedge clock); #1;
        // second busy cycle; reset lands between edges
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if ({acc, zero_flag, carry_flag, jump_valid, jump_target, busy, halted, illegal} !==
            {8'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset_mid_mul: got %h expected %h", obs_vec(), exp_vec());
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b expected 1", instr_ready);
        end
        idle(6);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL no_spill_after_reset: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_muli();
        test_add_sub();
        test_jumps();
        test_illegal();
        test_random();
        test_halt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/accumulator_execute.md
Name: accumulator_execute

Overview:
- Execute stage of the PUC CPU. It sits directly downstream of the program counter / instruction-fetch path and consumes the instruction word that path produces.
- It decodes each instruction into an opcode and an immediate, and updates an accumulator plus zero and carry flags.
- It runs an iterative shift-add multiply over several cycles.
- It returns jump requests to the program counter, and halts the machine on HALT.

Parameters:
- WIDTH, 8, instruction word width; opcode is instr[WIDTH-1:WIDTH-4], immediate is instr[WIDTH-5:0] (IMM_WIDTH = WIDTH-4).
- COUNTER_WIDTH, 4, program counter width; jump target is the immediate zero-extended or truncated to this width.
- ACC_WIDTH, 8, accumulator width; the immediate is zero-extended to ACC_WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- instruction  input  WIDTH  instruction word from the fetch path.
- instr_valid  input  1  instruction is present.
- instr_ready  output  1  stage can accept an instruction this cycle.
- acc  output  ACC_WIDTH  accumulator.
- zero_flag  output  1  accumulator was zero after its last write.
- carry_flag  output  1  carry/borrow from the last ADDI/SUBI.
- jump_valid  output  1  one-cycle jump request.
- jump_target  output  COUNTER_WIDTH  jump destination.
- busy  output  1  multiply in progress.
- halted  output  1  HALT executed.
- illegal  output  1  one-cycle pulse, undefined opcode accepted.

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is asynchronous and active-high.
- Reset values:
  - acc=0, zero_flag=1, carry_flag=0.
  - jump_valid=0, jump_target=0, busy=0, halted=0, illegal=0.
  - State is EXEC, so instr_ready=1.
- Asserting reset in any state, including mid-multiply or while halted, aborts all activity and restores these values.
- Handshake: an instruction is accepted on a rising edge where instr_valid && instr_ready. instr_ready is combinational from state: 1 only in EXEC.
- States:
  - EXEC: accepts instructions. Single-cycle ops take effect at the acceptance edge (latency 1). MULI goes to MUL; HALT goes to HALTED; all other opcodes stay in EXEC.
  - MUL: busy=1, instr_ready=0. Runs IMM_WIDTH iterations, one per clock. On the final iteration acc is written and the state returns to EXEC. Total ready-low time is exactly IMM_WIDTH cycles.
  - HALTED: halted=1, instr_ready=0. instr_valid is ignored. Exit is by reset only.
- Opcodes (imm = zero-extended immediate):
  - 0 NOP: no state change.
  - 1 LDI: acc=imm.
  - 2 ADDI: {carry,acc}=acc+imm.
  - 3 SUBI: acc=acc-imm; carry=1 on borrow.
  - 4 ANDI, 5 ORI, 6 XORI: bitwise operation with imm.
  - 7 SHLI: acc=acc<<imm[2:0]; carry unchanged.
  - 8 MULI: acc=(acc*imm) mod 2^ACC_WIDTH, computed by shift-add.
  - 9 JMP: jump_valid=1, jump_target=imm.
  - A JZ: as JMP, but only if zero_flag=1 at the acceptance edge. That value reflects any instruction accepted on the previous edge.
  - B HALT: enter HALTED.
  - C–F: treated as NOP, with an illegal pulse for one cycle.
- Flags:
  - zero_flag updates on every acc write (LDI, ALU ops, MULI completion) to (new acc==0); other ops leave it unchanged.
  - carry_flag updates only on ADDI/SUBI.
- jump_valid is registered and high exactly one cycle per taken jump. jump_target holds its value until the next taken jump. Flushing wrong-path instructions is the fetch side's job.
- Arithmetic wraps modulo 2^ACC_WIDTH. MULI with imm=0 still takes IMM_WIDTH cycles and yields 0.
- Back-to-back valid instructions are accepted every cycle in EXEC.

Decomposition:
- Package puc_pkg:
  - opcode_t enum (NOP…HALT), state_t enum (EXEC, MUL, HALTED).
  - IMM_WIDTH derivation, reset-value constants.
- One natural sub-module: shift_add_multiplier.
  - Interface: start, multiplicand, multiplier, product, done.
  - Iteration counter of $clog2(IMM_WIDTH+1) bits.
  - Internal to MUL state; aborts on reset.

Test Plan:
- Reset, then LDI 5 (0x15): at the next edge acc=5, zero_flag=0, instr_ready stays 1.
- LDI F, then MULI F (0x8F): busy=1 and instr_ready=0 for exactly 4 cycles, then acc=225 (0xE1), zero_flag=0. An instr_valid held during busy is not accepted until ready returns.
- From acc=225: ADDI F → 240, ADDI F → 255, ADDI 1 → acc=0, carry=1, zero=1. Then SUBI 1 → acc=255, carry=1, zero=0.
- JZ 7 with zero_flag=1 → jump_valid high exactly one cycle, jump_target=7. JZ 7 with zero_flag=0 → no pulse. JMP 3 → pulse, target=3.
- HALT (0xB0) → halted=1, instr_ready=0. Subsequent LDI 9 leaves acc unchanged. Opcode 0xE0 in EXEC → illegal pulse for one cycle, no other change.
- Assert reset asynchronously mid-MULI (second busy cycle) → all outputs take reset values immediately, without waiting for a clock edge; instr_ready=1 after reset deasserts.
